// File: rtl/prog_loader_if.sv
// prog_loader_if
// Groups the host byte-stream handshake, the CPU instruction-fetch port and
// the loader status flags into one bundle.
//   wr_valid/wr_data/wr_ready : host byte stream. A byte moves when valid & ready
//                               are both high at a clock edge.
//   rd_addr/rd_data           : CPU fetch port. The read is combinational.
//   cpu_run                   : CPU may execute. Drives the CPU active-low reset.
//   busy/done/err             : loader status.
// Modports:
//   master : host/CPU side. Drives the stream and the fetch address.
//   slave  : the loader.
interface prog_loader_if;
    logic       wr_valid;
    logic [7:0] wr_data;
    logic       wr_ready;
    logic [3:0] rd_addr;
    logic [7:0] rd_data;
    logic       cpu_run;
    logic       busy;
    logic       done;
    logic       err;

    modport master (
        output wr_valid, wr_data, rd_addr,
        input  wr_ready, rd_data, cpu_run, busy, done, err
    );

    modport slave (
        input  wr_valid, wr_data, rd_addr,
        output wr_ready, rd_data, cpu_run, busy, done, err
    );
endinterface

// File: rtl/prog_loader.sv
// prog_loader
// Receives a program frame from the host and writes it into a 16x8
// instruction memory. The frame is: HEADER, LEN, LEN data bytes, CHK.
// CHK is the sum of the data bytes modulo 256. The CPU is held in reset
// (cpu_run=0) from the HEADER byte until a frame completes successfully.
// After a good frame shorter than 16 bytes, the unused tail of memory is
// zeroed one word per cycle. During that time wr_ready is low.
// Ports:
//   clk   : single clock. All state changes happen on the rising edge.
//   reset : synchronous, active-high.
//   bus   : prog_loader_if.slave. Carries the byte stream, the fetch port
//           and the status flags.
module prog_loader #(
    parameter logic [7:0] HEADER = 8'hA5
) (
    input logic          clk,
    input logic          reset,
    prog_loader_if.slave bus
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LEN,
        ST_DATA,
        ST_SUM,
        ST_CLEAR
    } state_t;

    state_t     state_q;
    // ptr is 5 bits wide, so len==16 can be compared without wrapping to 0.
    logic [4:0] ptr_q;
    logic [4:0] len_q;
    logic [7:0] sum_q;
    logic [7:0] mem_q [16];
    logic       cpu_run_q;
    logic       done_q;
    logic       err_q;

    logic       wr_fire;
    logic [7:0] sum_d;
    logic [4:0] ptr_d;
    logic       len_ok;
    logic       last_data;

    assign bus.wr_ready = (state_q != ST_CLEAR);
    assign wr_fire      = bus.wr_valid & bus.wr_ready;
    assign sum_d        = sum_q + bus.wr_data;
    assign ptr_d        = ptr_q + 5'd1;
    assign len_ok       = (bus.wr_data != 8'd0) && (bus.wr_data <= 8'd16);
    assign last_data    = (ptr_q == len_q - 5'd1);

    assign bus.rd_data  = mem_q[bus.rd_addr];
    assign bus.cpu_run  = cpu_run_q;
    assign bus.done     = done_q;
    assign bus.err      = err_q;
    assign bus.busy     = (state_q != ST_IDLE);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            ptr_q     <= '0;
            len_q     <= '0;
            sum_q     <= '0;
            cpu_run_q <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            for (int i = 0; i < 16; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            case (state_q)
                ST_IDLE: begin
                    // Bytes other than HEADER are dropped while idle.
                    if (wr_fire && bus.wr_data == HEADER) begin
                        state_q   <= ST_LEN;
                        cpu_run_q <= 1'b0;
                        done_q    <= 1'b0;
                        err_q     <= 1'b0;
                        ptr_q     <= '0;
                        sum_q     <= '0;
                    end
                end
                ST_LEN: begin
                    if (wr_fire) begin
                        if (len_ok) begin
                            len_q   <= bus.wr_data[4:0];
                            state_q <= ST_DATA;
                        end else begin
                            err_q   <= 1'b1;
                            state_q <= ST_IDLE;
                        end
                    end
                end
                ST_DATA: begin
                    // A byte equal to HEADER is ordinary payload here.
                    if (wr_fire) begin
                        mem_q[ptr_q[3:0]] <= bus.wr_data;
                        sum_q             <= sum_d;
                        ptr_q             <= ptr_d;
                        if (last_data) begin
                            state_q <= ST_SUM;
                        end
                    end
                end
                ST_SUM: begin
                    if (wr_fire) begin
                        if (bus.wr_data == sum_q) begin
                            if (len_q == 5'd16) begin
                                state_q   <= ST_IDLE;
                                done_q    <= 1'b1;
                                cpu_run_q <= 1'b1;
                            end else begin
                                // ptr already equals len, so zeroing starts
                                // at the first unused word.
                                state_q <= ST_CLEAR;
                            end
                        end else begin
                            // Partially written memory is left as is.
                            err_q   <= 1'b1;
                            state_q <= ST_IDLE;
                        end
                    end
                end
                ST_CLEAR: begin
                    mem_q[ptr_q[3:0]] <= 8'h00;
                    ptr_q             <= ptr_d;
                    if (ptr_q[3:0] == 4'hF) begin
                        state_q   <= ST_IDLE;
                        done_q    <= 1'b1;
                        cpu_run_q <= 1'b1;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_prog_loader.sv
module tb_prog_loader;

    logic clk;
    logic reset;

    prog_loader_if bus ();

    prog_loader #(.HEADER(8'hA5)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // ---------------- behavioural model ----------------
    // Frame-level view: in_frame, how many bytes arrived after the header,
    // and a countdown of zero-fill cycles that are still owed.
    logic       m_started = 1'b0;
    logic       m_acc = 1'b0;
    logic       m_in_frame = 1'b0;
    int         m_got = 0;
    int         m_len = 0;
    logic [7:0] m_sum = '0;
    int         m_clear_left = 0;
    logic       m_run = 1'b0;
    logic       m_done = 1'b0;
    logic       m_err = 1'b0;
    logic [7:0] m_mem [16];

    initial begin
        logic [7:0] b;
        forever begin
            @(posedge clk);
            m_started = 1'b1;
            m_acc = 1'b0;
            if (reset) begin
                m_in_frame = 1'b0; m_got = 0; m_len = 0; m_sum = '0;
                m_clear_left = 0; m_run = 1'b0; m_done = 1'b0; m_err = 1'b0;
                for (int i = 0; i < 16; i++) m_mem[i] = 8'h00;
            end else if (m_clear_left > 0) begin
                m_clear_left--;
                if (m_clear_left == 0) begin
                    for (int i = m_len; i < 16; i++) m_mem[i] = 8'h00;
                    m_done = 1'b1; m_run = 1'b1; m_in_frame = 1'b0;
                end
            end else if (bus.wr_valid) begin
                b = bus.wr_data;
                m_acc = 1'b1;
                if (!m_in_frame) begin
                    if (b == 8'hA5) begin
                        m_in_frame = 1'b1; m_got = 0; m_sum = '0;
                        m_run = 1'b0; m_done = 1'b0; m_err = 1'b0;
                    end
                end else if (m_got == 0) begin
                    if (b >= 8'd1 && b <= 8'd16) begin
                        m_len = int'(b); m_got = 1;
                    end else begin
                        m_err = 1'b1; m_in_frame = 1'b0;
                    end
                end else if (m_got <= m_len) begin
                    m_mem[m_got - 1] = b;
                    m_sum = m_sum + b;
                    m_got++;
                end else begin
                    if (b == m_sum) begin
                        if (m_len == 16) begin
                            m_done = 1'b1; m_run = 1'b1; m_in_frame = 1'b0;
                        end else begin
                            m_clear_left = 16 - m_len;
                        end
                    end else begin
                        m_err = 1'b1; m_in_frame = 1'b0;
                    end
                end
            end
        end
    end

    task automatic check1(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle compare of every output against the model.
    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (m_started) begin
                check1("wr_ready", {7'd0, bus.wr_ready}, {7'd0, (m_clear_left == 0)});
                check1("busy",     {7'd0, bus.busy},     {7'd0, m_in_frame});
                check1("done",     {7'd0, bus.done},     {7'd0, m_done});
                check1("err",      {7'd0, bus.err},      {7'd0, m_err});
                check1("cpu_run",  {7'd0, bus.cpu_run},  {7'd0, m_run});
                // The model zeroes the tail in one step, so rd_data is
                // only compared outside the zero-fill window.
                if (m_clear_left == 0)
                    check1($sformatf("rd_data[%0d]", bus.rd_addr), bus.rd_data, m_mem[bus.rd_addr]);
            end
        end
    end

    // ---------------- directed stimulus ----------------
    logic [7:0] fq[$];

    task automatic send(input logic [7:0] b);
        int n;
        bus.wr_valid = 1'b1;
        bus.wr_data  = b;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!m_acc && n < 50);
        checks++;
        if (!m_acc) begin
            errors++;
            $display("FAIL send_timeout actual=not_accepted required=accepted byte=%h", b);
        end
    endtask

    // A gap of idle cycles (wr_valid=0) is inserted before each byte.
    task automatic send_all(input int gap);
        foreach (fq[i]) begin
            if (gap > 0) begin
                bus.wr_valid = 1'b0;
                repeat (gap) @(negedge clk);
            end
            send(fq[i]);
        end
    endtask

    // Counts the cycles until done rises. wr_valid is still held high,
    // so a byte offered during zero-fill must not be consumed.
    task automatic wait_done(input int exp_n);
        int n;
        n = 0;
        while (!bus.done && n < 40) begin
            @(negedge clk);
            n++;
        end
        bus.wr_valid = 1'b0;
        check1("clear_cycles", n[7:0], exp_n[7:0]);
    endtask

    task automatic check_mem(input string tag, input logic [127:0] exp);
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            bus.rd_addr = i[3:0];
            #1;
            check1($sformatf("%s_mem[%0d]", tag, i), bus.rd_data, exp[8*i +: 8]);
        end
    endtask

    task automatic check_flags(input string tag, input logic d, input logic e,
                               input logic r, input logic bz);
        check1({tag, "_done"},    {7'd0, bus.done},    {7'd0, d});
        check1({tag, "_err"},     {7'd0, bus.err},     {7'd0, e});
        check1({tag, "_cpu_run"}, {7'd0, bus.cpu_run}, {7'd0, r});
        check1({tag, "_busy"},    {7'd0, bus.busy},    {7'd0, bz});
    endtask

    initial begin
        reset = 1'b1;
        bus.wr_valid = 1'b0;
        bus.wr_data = '0;
        bus.rd_addr = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        check1("rst_wr_ready", {7'd0, bus.wr_ready}, 8'd1);
        check_flags("rst", 1'b0, 1'b0, 1'b0, 1'b0);
        check_mem("rst", 128'h0);

        // Short frame with zero-fill of 13 words.
        fq = {8'hA5, 8'h03, 8'h91, 8'hA2, 8'h00, 8'h33};
        send_all(0);
        wait_done(13);
        check_flags("f3", 1'b1, 1'b0, 1'b1, 1'b0);
        check_mem("f3", 128'h00A291);

        // Bad checksum. The partial contents stay in memory.
        fq = {8'hA5, 8'h02, 8'h60, 8'h61, 8'hC2};
        send_all(0);
        bus.wr_valid = 1'b0;
        check_flags("badchk", 1'b0, 1'b1, 1'b0, 1'b0);
        check_mem("badchk", 128'h6160);

        // Illegal LEN, followed by a clean one-byte frame.
        fq = {8'hA5, 8'h11};
        send_all(0);
        bus.wr_valid = 1'b0;
        check_flags("badlen", 1'b0, 1'b1, 1'b0, 1'b0);
        fq = {8'hA5, 8'h01, 8'h92, 8'h92};
        send_all(0);
        wait_done(15);
        check_flags("f1", 1'b1, 1'b0, 1'b1, 1'b0);
        check_mem("f1", 128'h92);

        // Full 16-byte frame. done rises on the CHK edge itself.
        fq = {8'hA5, 8'h10};
        for (int i = 0; i < 16; i++) fq.push_back(i[7:0]);
        fq.push_back(8'h78);
        send_all(0);
        wait_done(0);
        check_flags("f16", 1'b1, 1'b0, 1'b1, 1'b0);
        check_mem("f16", 128'h0F0E0D0C_0B0A0908_07060504_03020100);

        // Reset in the middle of a frame, with wr_valid held during reset.
        fq = {8'hA5, 8'h04, 8'h11, 8'h22};
        send_all(0);
        bus.wr_data = 8'h33;
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        bus.wr_valid = 1'b0;
        check_flags("midrst", 1'b0, 1'b0, 1'b0, 1'b0);
        check_mem("midrst", 128'h0);
        fq = {8'h55};
        send_all(0);
        bus.wr_valid = 1'b0;
        check_flags("junk", 1'b0, 1'b0, 1'b0, 1'b0);

        // Same short frame with idle gaps between every byte.
        fq = {8'hA5, 8'h03, 8'h91, 8'hA2, 8'h00, 8'h33};
        send_all(2);
        wait_done(13);
        check_flags("gap", 1'b1, 1'b0, 1'b1, 1'b0);
        check_mem("gap", 128'h00A291);

        // HEADER values inside the payload are ordinary data.
        fq = {8'hA5, 8'h02, 8'hA5, 8'hA5, 8'h4A};
        send_all(0);
        wait_done(14);
        check_flags("hdrdata", 1'b1, 1'b0, 1'b1, 1'b0);
        check_mem("hdrdata", 128'hA5A5);

        repeat (2) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

endmodule
